// File: rtl/spi_xfer_ctrl_if.sv
// ---------------------------------------------------------------------------
// spi_xfer_ctrl_if
//   Bundles the signals around spi_xfer_ctrl: the command handshake from the
//   reader-command FSM and the SPI pin / SCK generator side.
//
//   Command side : start, rw, addr[5:0], wdata[7:0]  -> controller
//                  busy, done, err, rdata[7:0]       <- controller
//   SPI side     : sck_in, miso                      -> controller
//                  sck_en, ss_n, mosi                <- controller
//
//   slave  modport : used by spi_xfer_ctrl
//   master modport : used by whatever drives commands and models the pins
// ---------------------------------------------------------------------------
interface spi_xfer_ctrl_if;
    logic       start;
    logic       rw;
    logic [5:0] addr;
    logic [7:0] wdata;
    logic       busy;
    logic       done;
    logic       err;
    logic [7:0] rdata;
    logic       sck_en;
    logic       sck_in;
    logic       ss_n;
    logic       mosi;
    logic       miso;

    modport slave (
        input  start, rw, addr, wdata, sck_in, miso,
        output busy, done, err, rdata, sck_en, ss_n, mosi
    );

    modport master (
        output start, rw, addr, wdata, sck_in, miso,
        input  busy, done, err, rdata, sck_en, ss_n, mosi
    );
endinterface

// File: rtl/spi_xfer_ctrl.sv
// ---------------------------------------------------------------------------
// spi_xfer_ctrl
//   Sequences one 16-bit SPI register access to the RFID reader (mode 0,
//   MSB first): address byte {rw, addr, 0}, then data byte (wdata, or 0 for
//   reads). Owns ss_n with its setup / hold / gap timing, enables the external
//   SCK generator and follows its SCK to shift mosi and sample miso.
//
//   Ports
//     clk   : system clock, rising edge
//     rst   : synchronous, active-high reset
//     bus   : spi_xfer_ctrl_if.slave
//               start/rw/addr/wdata in, busy/done/err/rdata out,
//               sck_in/miso in, sck_en/ss_n/mosi out
//
//   Parameters
//     SETUP_CYC : clk cycles with ss_n low before sck_en rises (>=1)
//     HOLD_CYC  : clk cycles with ss_n low after the last detected SCK fall (>=1)
//     GAP_CYC   : clk cycles with ss_n high before returning to IDLE (>=1)
//     EDGE_TO   : max clk cycles between SCK edges before the access aborts (>=2)
// ---------------------------------------------------------------------------
module spi_xfer_ctrl #(
    parameter int SETUP_CYC = 4,
    parameter int HOLD_CYC  = 4,
    parameter int GAP_CYC   = 8,
    parameter int EDGE_TO   = 64
) (
    input  logic             clk,
    input  logic             rst,
    spi_xfer_ctrl_if.slave   bus
);

    localparam int CNT_MAX = (SETUP_CYC > HOLD_CYC)
                           ? ((SETUP_CYC > GAP_CYC) ? SETUP_CYC : GAP_CYC)
                           : ((HOLD_CYC  > GAP_CYC) ? HOLD_CYC  : GAP_CYC);
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int TO_W    = $clog2(EDGE_TO + 1);

    localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(SETUP_CYC - 1);
    localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'(HOLD_CYC - 1);
    localparam logic [CNT_W-1:0] GAP_LD   = CNT_W'(GAP_CYC - 1);
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(EDGE_TO - 1);
    localparam logic [4:0]       NBITS    = 5'd16;

    typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [4:0]       bitcnt;
    logic [TO_W-1:0]  tocnt;
    logic [14:0]      tx;       // frame bits not yet presented on mosi
    logic [7:0]       rx;       // only the last 8 sampled bits (data byte) matter
    logic             rw_q;
    logic             abort;
    logic             sck_q;

    logic             busy_r;
    logic             done_r;
    logic             err_r;
    logic [7:0]       rdata_r;
    logic             sck_en_r;
    logic             ss_n_r;
    logic             mosi_r;

    logic [15:0]      frame;
    logic             rise;
    logic             fall;

    assign frame = {bus.rw, bus.addr, 1'b0, (bus.rw ? 8'h00 : bus.wdata)};

    // Edge detect against the previous sample: lags SCK by one clk, and rise
    // and fall are mutually exclusive by construction.
    assign rise = bus.sck_in & ~sck_q;
    assign fall = ~bus.sck_in & sck_q;

    assign bus.busy   = busy_r;
    assign bus.done   = done_r;
    assign bus.err    = err_r;
    assign bus.rdata  = rdata_r;
    assign bus.sck_en = sck_en_r;
    assign bus.ss_n   = ss_n_r;
    assign bus.mosi   = mosi_r;

    // NOTE: every register in this block is assigned with <= so all of them
    // see the same pre-edge values; blocking here would create ordering races.
    always_ff @(posedge clk) begin
        // NOTE: reset is synchronous and covers every register; there is no
        // storage array here that would need to be left out of reset.
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            bitcnt   <= '0;
            tocnt    <= '0;
            tx       <= '0;
            rx       <= '0;
            rw_q     <= 1'b0;
            abort    <= 1'b0;
            sck_q    <= 1'b0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            err_r    <= 1'b0;
            rdata_r  <= 8'h00;
            sck_en_r <= 1'b0;
            ss_n_r   <= 1'b1;
            mosi_r   <= 1'b0;
        end else begin
            sck_q  <= bus.sck_in;
            done_r <= 1'b0;
            err_r  <= 1'b0;

            case (state)
                IDLE: begin
                    if (bus.start) begin
                        tx     <= frame[14:0];
                        mosi_r <= frame[15];
                        rw_q   <= bus.rw;
                        abort  <= 1'b0;
                        ss_n_r <= 1'b0;
                        busy_r <= 1'b1;
                        cnt    <= SETUP_LD;
                        state  <= SETUP;
                    end
                end

                SETUP: begin
                    if (cnt == '0) begin
                        sck_en_r <= 1'b1;
                        bitcnt   <= '0;
                        tocnt    <= '0;
                        state    <= SHIFT;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end

                SHIFT: begin
                    if (rise) begin
                        tocnt <= '0;
                        // Guard keeps bitcnt at 16 even if SCK misbehaves.
                        if (bitcnt != NBITS) begin
                            rx     <= {rx[6:0], bus.miso};
                            bitcnt <= bitcnt + 5'd1;
                        end
                    end else if (fall) begin
                        tocnt <= '0;
                        if (bitcnt == NBITS) begin
                            sck_en_r <= 1'b0;
                            mosi_r   <= 1'b0;
                            cnt      <= HOLD_LD;
                            state    <= HOLD;
                        end else begin
                            // Changing mosi only after a detected fall keeps
                            // it stable across the next rising SCK edge.
                            mosi_r <= tx[14];
                            tx     <= {tx[13:0], 1'b0};
                        end
                    end else if (tocnt == TO_LAST) begin
                        sck_en_r <= 1'b0;
                        mosi_r   <= 1'b0;
                        abort    <= 1'b1;
                        cnt      <= HOLD_LD;
                        state    <= HOLD;
                    end else begin
                        tocnt <= tocnt + TO_W'(1);
                    end
                end

                HOLD: begin
                    if (cnt == '0) begin
                        ss_n_r <= 1'b1;
                        done_r <= 1'b1;
                        err_r  <= abort;
                        if (rw_q && !abort) begin
                            rdata_r <= rx;
                        end
                        cnt   <= GAP_LD;
                        state <= GAP;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end

                GAP: begin
                    if (cnt == '0) begin
                        busy_r <= 1'b0;
                        state  <= IDLE;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end

                default: begin
                    busy_r   <= 1'b0;
                    sck_en_r <= 1'b0;
                    ss_n_r   <= 1'b1;
                    mosi_r   <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_xfer_ctrl.sv
// ---------------------------------------------------------------------------
// tb_spi_xfer_ctrl
//   Drives spi_xfer_ctrl through its command interface, models the SCK
//   generator (half-period 7 clk, idles low when disabled) and a mode-0 SPI
//   slave that shifts a response word out on miso. A negedge monitor records
//   the MOSI bits seen at SCK rises and the cycle stamps of pin edges.
// ---------------------------------------------------------------------------
module tb_spi_xfer_ctrl;

    localparam int SETUP_CYC = 4;
    localparam int HOLD_CYC  = 4;
    localparam int GAP_CYC   = 8;
    localparam int EDGE_TO   = 64;
    localparam int HALF      = 7;
    localparam int BUDGET    = 2000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    spi_xfer_ctrl_if bus ();

    spi_xfer_ctrl #(
        .SETUP_CYC (SETUP_CYC),
        .HOLD_CYC  (HOLD_CYC),
        .GAP_CYC   (GAP_CYC),
        .EDGE_TO   (EDGE_TO)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int total = 0;
    int bad   = 0;

    // ---------------- SCK generator model ----------------
    bit   stall = 1'b0;
    int   div   = 0;
    logic sck_r = 1'b0;

    always @(posedge clk) begin
        if (bus.sck_en !== 1'b1 || stall) begin
            sck_r <= 1'b0;
            div   <= 0;
        end else if (div == HALF - 1) begin
            sck_r <= ~sck_r;
            div   <= 0;
        end else begin
            div <= div + 1;
        end
    end
    assign bus.sck_in = sck_r;

    // ---------------- SPI slave model (mode 0) ----------------
    logic [15:0] resp    = 16'h0000;
    logic [15:0] miso_sr = 16'h0000;
    logic        sck_d   = 1'b0;
    logic        miso_r  = 1'b0;

    always @(posedge clk) begin
        sck_d <= sck_r;
        if (bus.ss_n === 1'b1) begin
            miso_sr <= resp;
            miso_r  <= resp[15];
        end else if (sck_d && !sck_r) begin
            miso_sr <= miso_sr << 1;
            miso_r  <= miso_sr[14];
        end
    end
    assign bus.miso = miso_r;

    // ---------------- monitor ----------------
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    bit          sck_s = 1'b0, ssn_s = 1'b1, en_s = 1'b0, busy_s = 1'b0;
    int          rises, dones, errs, ssn_falls;
    int          first_rise_cyc, last_fall_cyc, ssn_fall_cyc, ssn_rise_cyc;
    int          en_rise_cyc, en_fall_cyc, done_cyc, busy_fall_cyc, last_gap;
    bit          err_at_done;
    logic [15:0] mosi_cap;

    always @(negedge clk) begin
        if (sck_r && !sck_s) begin
            rises++;
            if (rises == 1) first_rise_cyc = cyc;
            mosi_cap = {mosi_cap[14:0], bus.mosi};
        end
        if (!sck_r && sck_s) last_fall_cyc = cyc;
        if (bus.ss_n === 1'b0 && ssn_s) begin
            ssn_falls++;
            ssn_fall_cyc = cyc;
            last_gap     = cyc - ssn_rise_cyc;
        end
        if (bus.ss_n === 1'b1 && !ssn_s) ssn_rise_cyc = cyc;
        if (bus.sck_en === 1'b1 && !en_s) en_rise_cyc = cyc;
        if (bus.sck_en === 1'b0 && en_s)  en_fall_cyc = cyc;
        if (bus.busy === 1'b0 && busy_s)  busy_fall_cyc = cyc;
        if (bus.done === 1'b1) begin
            dones++;
            done_cyc    = cyc;
            err_at_done = bus.err;
        end
        if (bus.err === 1'b1) errs++;
        sck_s  = sck_r;
        ssn_s  = (bus.ss_n !== 1'b0);
        en_s   = (bus.sck_en === 1'b1);
        busy_s = (bus.busy === 1'b1);
    end

    task automatic clear_mon();
        rises = 0; dones = 0; errs = 0; ssn_falls = 0;
        first_rise_cyc = -1; last_fall_cyc = -1; ssn_fall_cyc = -1;
        ssn_rise_cyc = -1; en_rise_cyc = -1; en_fall_cyc = -1;
        done_cyc = -1; busy_fall_cyc = -1; last_gap = 0;
        err_at_done = 1'b0; mosi_cap = 16'h0000;
    endtask

    // ---------------- reference model ----------------
    logic [7:0] exp_rdata = 8'h00;

    function automatic logic [15:0] frame_of(input bit r, input logic [5:0] a,
                                             input logic [7:0] d);
        return {r, a, 1'b0, (r ? 8'h00 : d)};
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic pulse_start(input bit r, input logic [5:0] a, input logic [7:0] d);
        @(posedge clk); #1;
        bus.start = 1'b1; bus.rw = r; bus.addr = a; bus.wdata = d;
        @(posedge clk); #1;
        bus.start = 1'b0;
    endtask

    task automatic wait_done_idle(output bit finished);
        bit got_done = 1'b0;
        bit got_idle = 1'b0;
        for (int i = 0; i < BUDGET && !got_done; i++) begin
            @(negedge clk);
            if (bus.done === 1'b1) got_done = 1'b1;
        end
        for (int i = 0; i < GAP_CYC + 8 && got_done && !got_idle; i++) begin
            @(negedge clk);
            if (bus.busy === 1'b0) got_idle = 1'b1;
        end
        @(negedge clk);
        finished = got_done && got_idle;
    endtask

    task automatic run_access(input bit r, input logic [5:0] a, input logic [7:0] d,
                              input logic [15:0] rsp, output bit finished);
        resp = rsp;
        clear_mon();
        pulse_start(r, a, d);
        wait_done_idle(finished);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        logic [5:0] ctl;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        ctl = {bus.busy, bus.done, bus.err, bus.sck_en, bus.ss_n, bus.mosi};
        total++; if (ctl !== 6'b000010) begin bad++; $display("FAIL reset_ctl: got %b expected %b", ctl, 6'b000010); end
        total++; if (bus.rdata !== 8'h00) begin bad++; $display("FAIL reset_rdata: got %h expected 00", bus.rdata); end
        rst = 1'b0;
        repeat (2) @(negedge clk);
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL idle_busy: got %b expected 0", bus.busy); end
    endtask

    task automatic test_write();
        bit fin;
        run_access(1'b0, 6'h01, 8'h0F, 16'($urandom), fin);
        total++; if (!fin) begin bad++; $display("FAIL write_finish: access did not complete"); end
        total++; if (mosi_cap !== 16'h020F) begin bad++; $display("FAIL write_mosi: got %h expected 020F", mosi_cap); end
        total++; if (rises !== 16) begin bad++; $display("FAIL write_rises: got %0d expected 16", rises); end
        total++; if (dones !== 1 || errs !== 0) begin bad++; $display("FAIL write_done_err: got done=%0d err=%0d expected 1/0", dones, errs); end
        total++; if (bus.rdata !== exp_rdata) begin bad++; $display("FAIL write_rdata: got %h expected %h", bus.rdata, exp_rdata); end
    endtask

    task automatic test_read();
        bit fin;
        run_access(1'b1, 6'h37, 8'h5A, {8'($urandom), 8'h92}, fin);
        exp_rdata = 8'h92;
        total++; if (!fin) begin bad++; $display("FAIL read_finish: access did not complete"); end
        total++; if (mosi_cap !== 16'hEE00) begin bad++; $display("FAIL read_mosi: got %h expected EE00", mosi_cap); end
        total++; if (bus.rdata !== exp_rdata) begin bad++; $display("FAIL read_rdata: got %h expected %h", bus.rdata, exp_rdata); end
        total++; if (dones !== 1 || err_at_done !== 1'b0) begin bad++; $display("FAIL read_done_err: got done=%0d err=%b expected 1/0", dones, err_at_done); end
    endtask

    task automatic test_start_spam();
        bit          fin;
        int          dones_first;
        logic [5:0]  a = 6'($urandom);
        logic [7:0]  d = 8'($urandom);
        resp = 16'($urandom);
        clear_mon();
        @(posedge clk); #1;
        bus.start = 1'b1; bus.rw = 1'b0; bus.addr = a; bus.wdata = d;
        for (int i = 0; i < 2 * BUDGET && ssn_falls < 2; i++) @(negedge clk);
        dones_first = dones;
        @(posedge clk); #1;
        bus.start = 1'b0;
        total++; if (ssn_falls < 2) begin bad++; $display("FAIL spam_second: got %0d ss_n falls expected 2", ssn_falls); end
        total++; if (dones_first !== 1) begin bad++; $display("FAIL spam_one_done: got %0d expected 1", dones_first); end
        total++; if (last_gap !== GAP_CYC + 1) begin bad++; $display("FAIL spam_gap: got %0d expected %0d", last_gap, GAP_CYC + 1); end
        wait_done_idle(fin);
        total++; if (!fin || dones !== 2) begin bad++; $display("FAIL spam_total_done: got %0d finished=%b expected 2", dones, fin); end
        total++; if (mosi_cap !== frame_of(1'b0, a, d) || rises !== 32) begin
            bad++; $display("FAIL spam_frame: got %h/%0d expected %h/32", mosi_cap, rises, frame_of(1'b0, a, d));
        end
    endtask

    task automatic test_reset_mid();
        bit fin;
        resp = {8'($urandom), 8'h5A};
        clear_mon();
        pulse_start(1'b1, 6'h37, 8'h00);
        for (int i = 0; i < BUDGET && rises < 9; i++) @(negedge clk);
        total++; if (rises < 9) begin bad++; $display("FAIL rstmid_rises: got %0d expected 9", rises); end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        total++; if ({bus.ss_n, bus.sck_en, bus.busy} !== 3'b100) begin
            bad++; $display("FAIL rstmid_pins: got ss_n/sck_en/busy=%b expected 100", {bus.ss_n, bus.sck_en, bus.busy});
        end
        exp_rdata = 8'h00;
        repeat (40) @(negedge clk);
        total++; if (dones !== 0) begin bad++; $display("FAIL rstmid_no_done: got %0d expected 0", dones); end
        total++; if (bus.rdata !== exp_rdata) begin bad++; $display("FAIL rstmid_rdata: got %h expected %h", bus.rdata, exp_rdata); end
        run_access(1'b1, 6'h37, 8'h00, {8'($urandom), 8'hC3}, fin);
        exp_rdata = 8'hC3;
        total++; if (!fin || mosi_cap !== 16'hEE00) begin bad++; $display("FAIL rstmid_fresh_mosi: got %h finished=%b expected EE00", mosi_cap, fin); end
        total++; if (bus.rdata !== exp_rdata || dones !== 1) begin bad++; $display("FAIL rstmid_fresh_rdata: got %h done=%0d expected %h/1", bus.rdata, dones, exp_rdata); end
    endtask

    task automatic test_timeout();
        bit fin;
        stall = 1'b1;
        run_access(1'b1, 6'($urandom), 8'($urandom), 16'($urandom), fin);
        stall = 1'b0;
        total++; if (!fin) begin bad++; $display("FAIL to_finish: access did not complete"); end
        total++; if (err_at_done !== 1'b1 || errs !== 1 || dones !== 1) begin
            bad++; $display("FAIL to_err: got err=%b errs=%0d dones=%0d expected 1/1/1", err_at_done, errs, dones);
        end
        total++; if (en_fall_cyc - en_rise_cyc !== EDGE_TO) begin bad++; $display("FAIL to_window: got %0d expected %0d", en_fall_cyc - en_rise_cyc, EDGE_TO); end
        total++; if (done_cyc - en_fall_cyc !== HOLD_CYC) begin bad++; $display("FAIL to_hold: got %0d expected %0d", done_cyc - en_fall_cyc, HOLD_CYC); end
        total++; if (bus.rdata !== exp_rdata || rises !== 0) begin bad++; $display("FAIL to_rdata: got %h rises=%0d expected %h/0", bus.rdata, rises, exp_rdata); end
    endtask

    task automatic test_timing();
        bit fin;
        int hold;
        run_access(1'b0, 6'($urandom), 8'($urandom), 16'($urandom), fin);
        hold = ssn_rise_cyc - last_fall_cyc;
        total++; if (!fin) begin bad++; $display("FAIL tim_finish: access did not complete"); end
        total++; if (en_rise_cyc - ssn_fall_cyc !== SETUP_CYC) begin bad++; $display("FAIL tim_setup: got %0d expected %0d", en_rise_cyc - ssn_fall_cyc, SETUP_CYC); end
        total++; if (first_rise_cyc - ssn_fall_cyc < SETUP_CYC) begin bad++; $display("FAIL tim_first_rise: got %0d expected >=%0d", first_rise_cyc - ssn_fall_cyc, SETUP_CYC); end
        total++; if (hold < HOLD_CYC || hold > HOLD_CYC + 1) begin bad++; $display("FAIL tim_hold: got %0d expected %0d..%0d", hold, HOLD_CYC, HOLD_CYC + 1); end
        total++; if (done_cyc !== ssn_rise_cyc) begin bad++; $display("FAIL tim_done_at_ssn: got %0d expected %0d", done_cyc, ssn_rise_cyc); end
        total++; if (busy_fall_cyc - done_cyc !== GAP_CYC) begin bad++; $display("FAIL tim_busy_gap: got %0d expected %0d", busy_fall_cyc - done_cyc, GAP_CYC); end
    endtask

    task automatic test_random();
        bit          fin;
        bit          r;
        logic [5:0]  a;
        logic [7:0]  d;
        logic [15:0] rsp;
        for (int n = 0; n < 8; n++) begin
            r   = 1'($urandom);
            a   = 6'($urandom);
            d   = 8'($urandom);
            rsp = 16'($urandom);
            run_access(r, a, d, rsp, fin);
            if (r) exp_rdata = rsp[7:0];
            total++; if (!fin || mosi_cap !== frame_of(r, a, d) || rises !== 16) begin
                bad++; $display("FAIL rand_frame[%0d]: got %h rises=%0d finished=%b expected %h/16", n, mosi_cap, rises, fin, frame_of(r, a, d));
            end
            total++; if (bus.rdata !== exp_rdata || errs !== 0) begin
                bad++; $display("FAIL rand_rdata[%0d]: got %h errs=%0d expected %h/0", n, bus.rdata, errs, exp_rdata);
            end
        end
    endtask

    initial begin
        bus.start = 1'b0;
        bus.rw    = 1'b0;
        bus.addr  = 6'h00;
        bus.wdata = 8'h00;
        clear_mon();
        test_reset();
        test_write();
        test_read();
        test_start_spam();
        test_reset_mid();
        test_timeout();
        test_timing();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
